alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 44 ++++
 rtl/alu_regfile.sv | 56 +++++
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared CPU definitions for the ALU sequencer: data width, opcode
// encodings, sequencer FSM states and the opcode-to-strobe decoder.
package alu_sequencer_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_OPS = 11;

    typedef enum logic [3:0] {
        OP_PASS = 4'd0,
        OP_NOT  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INC  = 4'd4,
        OP_DEC  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SHL  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Opcodes above SHL (11..15) are illegal.
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_SHL;
    endfunction

    // One-hot strobe vector, bit i set for opcode i; all-zero for illegal codes.
    function automatic logic [NUM_OPS-1:0] op_decode(input logic [3:0] op);
        logic [NUM_OPS-1:0] strb;
        strb = '0;
        for (int unsigned i = 0; i < NUM_OPS; i++) begin
            strb[i] = (op == 4'(i));
        end
        return strb;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// General register array for the ALU sequencer.
// Ports:
//   clk, rst             clock, synchronous active-high reset (all regs -> RST_VAL)
//   rd_en_i              capture both read ports on this edge
//   ra1_i/ra2_i          read addresses; rd1_o/rd2_o registered read data
//   dbg_addr_i           debug read index; dbg_data_o combinational read
//   we_i/wa_i/wd_i       write port
module alu_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned  NREGS   = 8,
    parameter logic [15:0]  RST_VAL = 16'h0000,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] rd1_q, rd2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= RST_VAL;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[wa_i] <= wd_i;
            end
            if (rd_en_i) begin
                rd1_q <= mem_q[ra1_i];
                rd2_q <= mem_q[ra2_i];
            end
        end
    end

    assign rd1_o = rd1_q;
    assign rd2_o = rd2_q;

    // While reset is held the array is reported at its reset value.
    assign dbg_data_o = rst ? RST_VAL : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer driving an external logic unit.
// Accepts one instruction in IDLE, reads operands (READ), strobes the logic
// unit and samples its result (EXEC), then writes back and retires (WRITE).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              instruction handshake
//   in_op, in_rd, in_rs1, in_rs2   opcode and register indices
//   in_imm_en, in_imm              immediate replaces rs2 as operand 2
//   passthrough..shl               one-hot operation strobes (EXEC only)
//   bus1, bus2 / bus3              operands out / result back from logic unit
//   done, err                      retire pulse, illegal-opcode pulse
//   result, flag_z, flag_n         last written-back value and its flags
//   dbg_addr, dbg_data             combinational register debug read
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned  NREGS   = 8,
    parameter logic [15:0]  RST_VAL = 16'h0000,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_imm_en,
    input  logic [15:0]   in_imm,
    output logic          passthrough,
    output logic          bnegate,
    output logic          add,
    output logic          sub,
    output logic          inc,
    output logic          dec,
    output logic          band,
    output logic          bor,
    output logic          bxor,
    output logic          shr,
    output logic          shl,
    output logic [15:0]   bus1,
    output logic [15:0]   bus2,
    input  logic [15:0]   bus3,
    output logic          done,
    output logic          err,
    output logic [15:0]   result,
    output logic          flag_z,
    output logic          flag_n,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [AW-1:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                imm_en_q, imm_en_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    logic                done_q, done_d, err_q, err_d;
    logic                rf_re, rf_we;
    logic [DATA_W-1:0]   rf_rd1, rf_rd2;
    logic                bus_live;
    logic [NUM_OPS-1:0]  strb;

    alu_regfile #(
        .NREGS   (NREGS),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rf_re),
        .ra1_i      (rs1_q),
        .ra2_i      (rs2_q),
        .rd1_o      (rf_rd1),
        .rd2_o      (rf_rd2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .wa_i       (rd_q),
        .wd_i       (alu_q)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_en_d = imm_en_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rf_re    = 1'b0;
        rf_we    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_READ;
                    op_d     = in_op;
                    rd_d     = in_rd;
                    rs1_d    = in_rs1;
                    rs2_d    = in_rs2;
                    imm_en_d = in_imm_en;
                    imm_d    = in_imm;
                end
            end
            ST_READ: begin
                rf_re   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_d   = bus3;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_is_legal(op_q)) begin
                    rf_we    = 1'b1;
                    result_d = alu_q;
                    flag_z_d = (alu_q == '0);
                    flag_n_d = alu_q[DATA_W-1];
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
            alu_q    <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_en_q <= imm_en_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held, so the
    // reset-state values appear in the reset cycle itself.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign bus_live = ((state_q == ST_EXEC) || (state_q == ST_WRITE)) && !rst;
    assign bus1     = bus_live ? rf_rd1 : '0;
    assign bus2     = !bus_live ? '0 : (imm_en_q ? imm_q : rf_rd2);
    assign strb     = ((state_q == ST_EXEC) && !rst) ? op_decode(op_q) : '0;

    assign passthrough = strb[OP_PASS];
    assign bnegate     = strb[OP_NOT];
    assign add         = strb[OP_ADD];
    assign sub         = strb[OP_SUB];
    assign inc         = strb[OP_INC];
    assign dec         = strb[OP_DEC];
    assign band        = strb[OP_AND];
    assign bor         = strb[OP_OR];
    assign bxor        = strb[OP_XOR];
    assign shr         = strb[OP_SHR];
    assign shl         = strb[OP_SHL];

    assign done   = done_q && !rst;
    assign err    = err_q && !rst;
    assign result = rst ? '0 : result_q;
    assign flag_z = flag_z_q && !rst;
    assign flag_n = flag_n_q && !rst;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int unsigned NR = 8;
    localparam logic [15:0] RV = 16'h5A3C;

    logic        clk, rst, in_valid, in_ready, in_imm_en;
    logic [3:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2, dbg_addr;
    logic [15:0] in_imm, bus1, bus2, bus3, result, dbg_data;
    logic passthrough, bnegate, add, sub, inc, dec, band, bor, bxor, shr, shl;
    logic done, err, flag_z, flag_n;

    alu_sequencer #(.NREGS(NR), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .passthrough(passthrough), .bnegate(bnegate), .add(add), .sub(sub),
        .inc(inc), .dec(dec), .band(band), .bor(bor), .bxor(bxor),
        .shr(shr), .shl(shl), .bus1(bus1), .bus2(bus2), .bus3(bus3),
        .done(done), .err(err), .result(result), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    // Logic unit behaviour: acts on whichever strobe is high.
    always_comb begin
        bus3 = 16'hDEAD;
        if (passthrough)  bus3 = bus2;
        else if (bnegate) bus3 = ~bus1;
        else if (add)     bus3 = bus1 + bus2;
        else if (sub)     bus3 = bus1 - bus2;
        else if (inc)     bus3 = bus1 + 16'd1;
        else if (dec)     bus3 = bus1 - 16'd1;
        else if (band)    bus3 = bus1 & bus2;
        else if (bor)     bus3 = bus1 | bus2;
        else if (bxor)    bus3 = bus1 ^ bus2;
        else if (shr)     bus3 = bus1 >> bus2;
        else if (shl)     bus3 = bus1 << bus2;
    end

    // Architectural meaning of each opcode on operands a (rs1) and b (rs2/imm).
    function automatic logic [15:0] op_eval(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return b;
            4'd1:    return ~a;
            4'd2:    return 16'(a + b);
            4'd3:    return 16'(a - b);
            4'd4:    return 16'(a + 16'd1);
            4'd5:    return 16'(a - 16'd1);
            4'd6:    return a & b;
            4'd7:    return a | b;
            4'd8:    return a ^ b;
            4'd9:    return a >> b;
            4'd10:   return a << b;
            default: return 16'h0000;
        endcase
    endfunction

    // Transaction-level model: one instruction in flight, timed by accept cycle.
    logic [15:0] m_regs [NR];
    logic [15:0] m_res, m_imm;
    logic        m_z, m_n, m_busy, m_done, m_err, m_ie, m_valid;
    logic [3:0]  m_op;
    logic [2:0]  m_rd, m_rs1, m_rs2;
    int          m_acc = 0;
    int          tcyc = 0;

    initial m_valid = 1'b0;

    always @(negedge clk) begin
        logic [10:0] strb_act, strb_exp;
        logic [15:0] v, opb;
        int age;
        tcyc++;
        age = tcyc - m_acc;
        strb_act = {shl, shr, bxor, bor, band, dec, inc, sub, add, bnegate, passthrough};
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_strobes", strb_act, 0);
            chk("rst_bus1", bus1, 0);
            chk("rst_bus2", bus2, 0);
            chk("rst_result", result, 0);
            chk("rst_flags", {flag_z, flag_n}, 0);
            chk("rst_dbg", dbg_data, RV);
        end else if (m_valid) begin
            chk("in_ready", in_ready, !m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("result", result, m_res);
            chk("flag_z", flag_z, m_z);
            chk("flag_n", flag_n, m_n);
            strb_exp = (m_busy && age == 1 && m_op <= 4'd10) ? (11'd1 << m_op) : 11'd0;
            chk("strobes", strb_act, strb_exp);
            if (!m_busy) begin
                chk("idle_bus1", bus1, 0);
                chk("idle_bus2", bus2, 0);
            end else if (age == 1) begin
                chk("exec_bus1", bus1, m_regs[m_rs1]);
                chk("exec_bus2", bus2, m_ie ? m_imm : m_regs[m_rs2]);
            end
            chk("dbg_data", dbg_data, m_regs[dbg_addr]);
        end
        // Advance the model to what the next rising edge must produce.
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = RV;
            m_busy = 0; m_done = 0; m_err = 0;
            m_res = 0; m_z = 0; m_n = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_done = 0;
            m_err = 0;
            if (m_busy && age == 2) begin
                m_busy = 0;
                m_done = 1;
                if (m_op <= 4'd10) begin
                    opb = m_ie ? m_imm : m_regs[m_rs2];
                    v = op_eval(m_op, m_regs[m_rs1], opb);
                    m_regs[m_rd] = v;
                    m_res = v;
                    m_z = (v == 16'h0000);
                    m_n = v[15];
                end else begin
                    m_err = 1;
                end
            end else if (!m_busy && in_valid) begin
                m_busy = 1;
                m_acc = tcyc + 1;
                m_op = in_op; m_rd = in_rd; m_rs1 = in_rs1; m_rs2 = in_rs2;
                m_ie = in_imm_en; m_imm = in_imm;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        dbg_addr = 3'($urandom_range(0, NR - 1));
    endtask

    task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    task automatic scramble();
        in_op = 4'($urandom); in_rd = 3'($urandom); in_rs1 = 3'($urandom);
        in_rs2 = 3'($urandom); in_imm_en = 1'($urandom); in_imm = 16'($urandom);
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [15:0] imm);
        int n;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_en = ie; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("accept_wait", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int lat, output logic [10:0] strb_seen, output logic err_seen);
        lat = 0;
        strb_seen = '0;
        err_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            strb_seen |= {shl, shr, bxor, bor, band, dec, inc, sub, add, bnegate, passthrough};
            cyc();
            if (done === 1'b1) begin
                lat = k;
                err_seen = err;
                break;
            end
        end
        chk("done_latency", lat, 3);
    endtask

    initial begin
        int lat, nacc, ndone;
        logic [10:0] sseen;
        logic eseen, took;
        rst = 1'b1; in_valid = 1'b0; dbg_addr = '0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm_en = 1'b0; in_imm = '0;
        repeat (3) cyc();
        chk("rst_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        peek(3'd0, RV, "rst_reg_value");

        // r1=3, r2=5, r3=r1+r2
        send(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3); wait_done(lat, sseen, eseen);
        send(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5); wait_done(lat, sseen, eseen);
        send(4'd2, 3'd3, 3'd1, 3'd2, 1'b0, 16'hFFFF); wait_done(lat, sseen, eseen);
        chk("add_strobe", sseen, 11'b000_0000_0100);
        chk("add_result", result, 16'd8);
        chk("add_flags", {flag_z, flag_n}, 2'b00);
        peek(3'd3, 16'd8, "add_r3");

        // r1=5, r4=r1-5 ; r6=FFFF, r7=r6+1
        send(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5); wait_done(lat, sseen, eseen);
        send(4'd3, 3'd4, 3'd1, 3'd0, 1'b1, 16'd5); wait_done(lat, sseen, eseen);
        peek(3'd4, 16'd0, "sub_r4");
        chk("sub_flag_z", flag_z, 1);
        send(4'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'hFFFF); wait_done(lat, sseen, eseen);
        send(4'd4, 3'd7, 3'd6, 3'd0, 1'b0, 16'd0); wait_done(lat, sseen, eseen);
        peek(3'd7, 16'd0, "inc_wrap_r7");
        chk("inc_wrap_flags", {flag_z, flag_n}, 2'b10);

        // illegal opcode 12 targeting r3
        send(4'd12, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0); wait_done(lat, sseen, eseen);
        chk("illegal_err", eseen, 1);
        chk("illegal_strobes", sseen, 0);
        chk("illegal_result_kept", result, 16'd0);
        chk("illegal_flags_kept", {flag_z, flag_n}, 2'b10);
        peek(3'd3, 16'd8, "illegal_r3_kept");

        // in_valid held high: one accept every fourth cycle
        nacc = 0;
        in_valid = 1'b1;
        scramble();
        in_op = 4'($urandom_range(0, 10));
        for (int i = 0; i < 40; i++) begin
            took = in_ready;
            chk("cont_ready_pattern", took, (i % 4) == 0);
            if (took === 1'b1) nacc++;
            cyc();
            if (took === 1'b1) begin
                scramble();
                in_op = 4'($urandom_range(0, 10));
            end
        end
        in_valid = 1'b0;
        chk("cont_accepts", nacc, 10);
        repeat (2) cyc();

        // reset during EXEC of ADD into r5
        send(4'd2, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_ready", in_ready, 1);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) ndone++;
            cyc();
        end
        chk("abort_no_done", ndone, 0);
        peek(3'd5, RV, "abort_r5");

        // SHL then NOT
        send(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0001); wait_done(lat, sseen, eseen);
        send(4'd10, 3'd2, 3'd1, 3'd0, 1'b1, 16'd4); wait_done(lat, sseen, eseen);
        peek(3'd2, 16'h0010, "shl_r2");
        send(4'd1, 3'd3, 3'd2, 3'd0, 1'b0, 16'd0); wait_done(lat, sseen, eseen);
        peek(3'd3, 16'hFFEF, "not_r3");
        chk("not_flag_n", flag_n, 1);

        // randomized traffic with occasional resets and aborts
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 3)) cyc();
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) cyc();
                rst = 1'b0;
            end
            send(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(0, 2)) cyc();
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                wait_done(lat, sseen, eseen);
            end
        end
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
